// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM state encoding and
//               helpers that derive the bit-timing counter endpoints from
//               the half-bit period.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states. The width is explicit so the encoding is fixed.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    // Default half-bit period, shared with the transmitter.
    localparam int unsigned c_clk_per_half_bit_dflt = 5208;

    // Counter value at mid start bit (half a bit after the falling edge).
    function automatic logic [31:0] e_half(input int unsigned half_bit);
        return 32'(half_bit - 1);
    endfunction

    // Counter value one full bit later (mid data / mid stop bit).
    function automatic logic [31:0] e_full(input int unsigned half_bit);
        return 32'((2 * half_bit) - 1);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input.
//               Both flops reset to RESET_VAL so the output starts in the
//               line's idle level rather than glitching after reset.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronized output (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first. Samples the synchronized line
//               at mid-bit and delivers each byte into a single holding
//               register with a valid/ack handshake. Flags framing errors
//               and overruns with one-cycle pulses.
// Ports       : clk      - system clock
//               rst      - asynchronous active-high reset
//               rxd      - serial input, asynchronous, idle high
//               rdata    - received byte, meaningful while rx_valid=1
//               rx_valid - holding register full (level)
//               rx_ack   - consumer pop; clears rx_valid next cycle
//               ferr     - pulse: stop bit sampled low
//               overrun  - pulse: byte delivered over an unread one
//               rx_busy  - FSM is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_HALF_BIT = c_clk_per_half_bit_dflt
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       ferr,
    output logic       overrun,
    output logic       rx_busy
);

    localparam logic [31:0] c_e_half = e_half(CLK_PER_HALF_BIT);
    localparam logic [31:0] c_e_full = e_full(CLK_PER_HALF_BIT);

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [31:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_rxd_s;
    logic        w_sample_data;
    logic        w_deliver;
    logic        w_frame_err;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxd_s)
    );

    // ------------------------------------------------------------------
    // Next-state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_sample_data = 1'b0;
        w_deliver     = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxd_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (r_cnt == c_e_half) begin
                    w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_e_full) begin
                    w_sample_data = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a short stop bit from the far
                // end still lets us see the next start edge.
                if (r_cnt == c_e_full) begin
                    w_state_nxt = S_IDLE;
                    if (w_rxd_s) begin
                        w_deliver = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state, bit timer, bit index and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state <= w_state_nxt;

            // The timer restarts on every state change and after each
            // data-bit sample, so each bit is timed from the previous one.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_sample_data) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_sample_data) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // LSB arrives first: shift right, new bit enters at the top.
            if (w_sample_data) begin
                r_shift <= {w_rxd_s, r_shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register, handshake and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= '0;
            rx_valid <= 1'b0;
            ferr     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ferr    <= w_frame_err;
            overrun <= w_deliver && rx_valid && !rx_ack;

            // A delivery wins over an ack in the same cycle: the ack pops
            // the old byte and the new one takes its place.
            if (w_deliver) begin
                rdata    <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (r_state != S_IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with a half-bit
//               period of 4 clocks (8-clock bits). A simple transmitter
//               task drives rxd on falling clock edges; outputs are
//               observed on falling edges, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int unsigned c_half = 4;
    localparam int          c_bit  = 2 * c_half;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rdata;
    logic       rx_valid;
    logic       rx_ack;
    logic       ferr;
    logic       overrun;
    logic       rx_busy;

    uart_rx #(
        .CLK_PER_HALF_BIT (c_half)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .ferr     (ferr),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk   = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         t0      = 0;
    int         t_rise  = -1;
    int         t_ferr  = -1;
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    int         ack_at  = -1;
    bit         auto_ack = 1'b0;
    bit         busy_seen = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, record what the DUT shows,
    // then set rx_ack for the following cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ferr) begin
            n_ferr++;
            if (t_ferr < 0) t_ferr = cyc - t0;
        end
        if (overrun) n_ovr++;
        if (rx_valid) n_valid++;
        if (rx_busy) busy_seen = 1'b1;
        if (rx_valid && !prev_valid && t_rise < 0) t_rise = cyc - t0;
        prev_valid = rx_valid;
        if (auto_ack && rx_valid && !rx_ack) begin
            got.push_back(rdata);
            rx_ack = 1'b1;
        end else if (ack_at >= 0 && (cyc - t0) == ack_at) begin
            rx_ack = 1'b1;
        end else begin
            rx_ack = 1'b0;
        end
    endtask

    // 8N1 frame; stop_val=0 produces a framing error, stop_cycles shortens
    // the stop bit for back-to-back traffic.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_cycles);
        t0     = cyc;
        t_rise = -1;
        t_ferr = -1;
        rxd    = 1'b0;
        repeat (c_bit) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (c_bit) tick();
        end
        rxd = stop_val;
        repeat (stop_cycles) tick();
        rxd = 1'b1;
    endtask

    initial begin
        logic [7:0] part;
        rst    = 1'b1;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdata",   32'(rdata),    32'h0);
        check("rst_valid",   32'(rx_valid), 32'h0);
        check("rst_ferr",    32'(ferr),     32'h0);
        check("rst_overrun", 32'(overrun),  32'h0);
        check("rst_busy",    32'(rx_busy),  32'h0);
        rst = 1'b0;
        repeat (4) tick();

        // 0xA5, ack two cycles after rx_valid rises
        n_valid = 0; n_ferr = 0; n_ovr = 0;
        send_frame(8'hA5, 1'b1, c_bit);
        check("a5_latency", 32'(t_rise), 32'd79);
        check("a5_rdata",   32'(rdata),  32'hA5);
        tick();
        rx_ack = 1'b1;
        tick();
        check("a5_valid_cycles", 32'(n_valid),  32'd3);
        check("a5_valid_clear",  32'(rx_valid), 32'h0);
        check("a5_ferr",         32'(n_ferr),   32'd0);
        check("a5_overrun",      32'(n_ovr),    32'd0);
        check("a5_busy",         32'(rx_busy),  32'h0);

        // Back-to-back frames with 0.9-bit stop bits, acked on arrival
        got.delete(); n_ferr = 0; n_ovr = 0;
        auto_ack = 1'b1;
        send_frame(8'h00, 1'b1, 7);
        send_frame(8'hFF, 1'b1, 7);
        send_frame(8'h5A, 1'b1, 7);
        repeat (10) tick();
        auto_ack = 1'b0;
        check("b2b_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("b2b_byte0", 32'(got[0]), 32'h00);
            check("b2b_byte1", 32'(got[1]), 32'hFF);
            check("b2b_byte2", 32'(got[2]), 32'h5A);
        end
        check("b2b_ferr",    32'(n_ferr), 32'd0);
        check("b2b_overrun", 32'(n_ovr),  32'd0);

        // Framing error on 0x3C, then a good 0x81
        n_valid = 0; n_ferr = 0; n_ovr = 0;
        send_frame(8'h3C, 1'b0, c_bit);
        check("ferr_pulse",  32'(n_ferr),  32'd1);
        check("ferr_time",   32'(t_ferr),  32'd79);
        check("ferr_valid",  32'(n_valid), 32'd0);
        repeat (16) tick();
        check("ferr_busy_after", 32'(rx_busy), 32'h0);
        send_frame(8'h81, 1'b1, c_bit);
        check("ferr_next_valid", 32'(rx_valid), 32'h1);
        check("ferr_next_rdata", 32'(rdata),    32'h81);
        check("ferr_no_more",    32'(n_ferr),   32'd1);
        check("ferr_overrun",    32'(n_ovr),    32'd0);
        rx_ack = 1'b1;
        tick();
        tick();

        // Overrun: 0x11 then 0x22 without ack
        n_ferr = 0; n_ovr = 0;
        send_frame(8'h11, 1'b1, c_bit);
        check("ovr_first", 32'(rdata), 32'h11);
        send_frame(8'h22, 1'b1, c_bit);
        check("ovr_pulse", 32'(n_ovr),    32'd1);
        check("ovr_rdata", 32'(rdata),    32'h22);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_ferr",  32'(n_ferr),   32'd0);

        // Same again, but ack in the delivery cycle: no overrun
        n_ovr  = 0;
        ack_at = 78;
        send_frame(8'h44, 1'b1, c_bit);
        ack_at = -1;
        check("ackdel_overrun", 32'(n_ovr),    32'd0);
        check("ackdel_rdata",   32'(rdata),    32'h44);
        check("ackdel_valid",   32'(rx_valid), 32'h1);
        rx_ack = 1'b1;
        tick();
        tick();
        check("ackdel_clear", 32'(rx_valid), 32'h0);

        // Ack while empty is ignored
        rx_ack = 1'b1;
        tick();
        tick();
        check("ack_empty", 32'(rx_valid), 32'h0);

        // Three-cycle low glitch on idle line
        busy_seen = 1'b0; n_valid = 0; n_ferr = 0;
        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        repeat (12) tick();
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_busy_end",  32'(rx_busy),   32'h0);
        check("glitch_valid",     32'(n_valid),   32'd0);
        check("glitch_ferr",      32'(n_ferr),    32'd0);

        // Reset in the middle of data bit 4 of 0xC3, with a byte pending
        send_frame(8'h96, 1'b1, c_bit);
        check("pre_rst_rdata", 32'(rdata), 32'h96);
        part = 8'hC3;
        rxd  = 1'b0;
        repeat (c_bit) tick();
        for (int i = 0; i < 4; i++) begin
            rxd = part[i];
            repeat (c_bit) tick();
        end
        rxd = part[4];
        repeat (c_half) tick();
        check("mid_busy", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_rdata",   32'(rdata),    32'h0);
        check("arst_valid",   32'(rx_valid), 32'h0);
        check("arst_busy",    32'(rx_busy),  32'h0);
        check("arst_ferr",    32'(ferr),     32'h0);
        check("arst_overrun", 32'(overrun),  32'h0);
        rxd = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_ferr = 0; n_ovr = 0;
        repeat (4) tick();
        send_frame(8'h7E, 1'b1, c_bit);
        check("post_rst_rdata", 32'(rdata),    32'h7E);
        check("post_rst_valid", 32'(rx_valid), 32'h1);
        check("post_rst_ferr",  32'(n_ferr),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
